bus_periph: RTL



---
 rtl/bus_periph.sv | 137 +++++++++++++
 1 files changed

// File: rtl/bus_periph.sv
// rtl/bus_periph.sv - memory-mapped GPIO ports and prescaled compare timer on the 12-bit CPU bus
module bus_periph #(
  parameter logic [11:0] BASE     = 12'hFF0,
  parameter int          PRESCALE = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] bus_addr,
  input  logic [3:0]  bus_data_w,
  input  logic        bus_data_rw,
  output logic [3:0]  bus_data_r,
  output logic        sel,
  input  logic [7:0]  gpio_in,
  output logic [7:0]  gpio_out,
  output logic        timer_irq
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE - 1);

  logic [7:0]    gpi_meta;
  logic [7:0]    gpi_sync;
  logic [7:0]    count;
  logic [7:0]    compare;
  logic [2:0]    ctrl;
  logic          match;
  logic [PW-1:0] presc;
  logic [3:0]    shadow;

  logic [3:0] offset;
  logic       wr;
  logic       rd;
  logic       en;
  logic       tick;
  logic       hit;

  assign sel    = (bus_addr[11:4] == BASE[11:4]);
  assign offset = bus_addr[3:0];
  assign wr     = sel & bus_data_rw;
  assign rd     = sel & ~bus_data_rw;
  assign en     = ctrl[0];
  assign tick   = en && (presc == PS_MAX);
  assign hit    = tick && (count == compare);

  // Both operands are flop outputs, so the AND cannot glitch.
  assign timer_irq = match & ctrl[1];

  // Output port nibbles and timer configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_out <= 8'h00;
      compare  <= 8'h00;
      ctrl     <= 3'b000;
    end else if (wr) begin
      case (offset)
        4'h0: gpio_out[3:0] <= bus_data_w;
        4'h1: gpio_out[7:4] <= bus_data_w;
        4'h6: compare[3:0]  <= bus_data_w;
        4'h7: compare[7:4]  <= bus_data_w;
        4'h8: ctrl          <= bus_data_w[2:0];
        default: ;
      endcase
    end
  end

  // Two-flop synchroniser for the asynchronous input port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpi_meta <= 8'h00;
      gpi_sync <= 8'h00;
    end else begin
      gpi_meta <= gpio_in;
      gpi_sync <= gpi_meta;
    end
  end

  // Prescaler: free-runs 0..PRESCALE-1 while enabled, parked at 0 otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if ((wr && offset == 4'h8 && !bus_data_w[0]) || !en || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Timer count; autoclear only applies on a compare hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'h00;
    end else if (tick) begin
      count <= (hit && ctrl[2]) ? 8'h00 : count + 8'h01;
    end
  end

  // Match flag: a hit in the same cycle as a W1C keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match <= 1'b0;
    end else if (hit) begin
      match <= 1'b1;
    end else if (wr && offset == 4'h9 && bus_data_w[0]) begin
      match <= 1'b0;
    end
  end

  // Latch the pre-increment high count nibble whenever the low nibble is read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= 4'h0;
    end else if (rd && offset == 4'h4) begin
      shadow <= count[7:4];
    end
  end

  // Zero-latency read mux straight from register state.
  always_comb begin
    bus_data_r = 4'h0;
    if (rd) begin
      case (offset)
        4'h0: bus_data_r = gpio_out[3:0];
        4'h1: bus_data_r = gpio_out[7:4];
        4'h2: bus_data_r = gpi_sync[3:0];
        4'h3: bus_data_r = gpi_sync[7:4];
        4'h4: bus_data_r = count[3:0];
        4'h5: bus_data_r = shadow;
        4'h6: bus_data_r = compare[3:0];
        4'h7: bus_data_r = compare[7:4];
        4'h8: bus_data_r = {1'b0, ctrl};
        4'h9: bus_data_r = {3'b000, match};
        default: bus_data_r = 4'h0;
      endcase
    end
  end

endmodule
